// File: rtl/cmd_pkg.sv
// Shared command-path definitions: header constants and the assembler state encoding.
package cmd_pkg;

  localparam logic [15:0] HEADER       = 16'hC7E5;
  localparam logic [15:0] UPDATAHEADER = 16'hE97B;
  localparam logic [7:0]  HDR_B0       = 8'hC7;
  localparam logic [7:0]  HDR_B1       = 8'hE5;

  typedef enum logic {
    S_EMPTY,
    S_HALF
  } state_t;

endpackage

// File: rtl/cmdasm_timeout.sv
// Inter-byte timeout counter: clear, count-enable and an expire flag at TIMEOUT_CYCLES-1.
module cmdasm_timeout #(
  parameter int unsigned TIMEOUT_CYCLES = 1000
) (
  input  logic clk_in,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES);

  logic [CntW-1:0] tmo_cnt;

  assign expire = (tmo_cnt == CntW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk_in) begin
    if (rst || clr) begin
      tmo_cnt <= '0;
    end else if (en && !expire) begin
      tmo_cnt <= tmo_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/cmd_word_assembler.sv
// Packs a host byte stream into 16-bit words with timeout drop and C7,E5 header realignment.
// Define CMDASM_ERRCNT_EN to add the saturating err_cnt output.
module cmd_word_assembler
  import cmd_pkg::state_t;
  import cmd_pkg::S_EMPTY;
  import cmd_pkg::S_HALF;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1000,
  parameter logic [7:0]  HDR_B0         = cmd_pkg::HDR_B0,
  parameter logic [7:0]  HDR_B1         = cmd_pkg::HDR_B1
`ifdef CMDASM_ERRCNT_EN
  ,
  parameter int unsigned CNT_W          = 16
`endif
) (
  input  logic        clk_in,
  input  logic        rst,
  input  logic [7:0]  byte_in,
  input  logic        byte_valid,
  input  logic        flush,
  output logic [15:0] ok2,
  output logic        data_valid,
  output logic        timeout_flag,
  output logic        realign_flag
`ifdef CMDASM_ERRCNT_EN
  ,
  output logic [CNT_W-1:0] err_cnt
`endif
);

  state_t     state;
  logic [7:0] lo_byte;
  logic [7:0] last_byte;
  logic       last_vld;
  logic       tmo_expire;
  logic       realign_hit;
  logic       tmo_hit;

  cmdasm_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk_in(clk_in),
    .rst   (rst),
    .clr   (state == S_EMPTY),
    .en    (state == S_HALF && !byte_valid && !flush),
    .expire(tmo_expire)
  );

  always_comb begin
    realign_hit = (state == S_EMPTY) && byte_valid && !flush && last_vld &&
                  (last_byte == HDR_B0) && (byte_in == HDR_B1);
    tmo_hit     = (state == S_HALF) && !byte_valid && !flush && tmo_expire;
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      state        <= S_EMPTY;
      ok2          <= '0;
      data_valid   <= 1'b0;
      timeout_flag <= 1'b0;
      realign_flag <= 1'b0;
      lo_byte      <= '0;
      last_byte    <= '0;
      last_vld     <= 1'b0;
    end else begin
      data_valid   <= 1'b0;
      timeout_flag <= 1'b0;
      realign_flag <= 1'b0;
      if (flush) begin
        state    <= S_EMPTY;
        last_vld <= 1'b0;
      end else if (realign_hit) begin
        ok2          <= {HDR_B1, HDR_B0};
        data_valid   <= 1'b1;
        realign_flag <= 1'b1;
        last_byte    <= byte_in;
        last_vld     <= (byte_in == HDR_B0);
      end else if (tmo_hit) begin
        timeout_flag <= 1'b1;
        last_vld     <= 1'b0;
        state        <= S_EMPTY;
      end else if (byte_valid) begin
        last_byte <= byte_in;
        if (state == S_EMPTY) begin
          lo_byte  <= byte_in;
          last_vld <= 1'b1;
          state    <= S_HALF;
        end else begin
          ok2        <= {byte_in, lo_byte};
          data_valid <= 1'b1;
          // A completing C7 stays eligible to start a realign on the next byte.
          last_vld   <= (byte_in == HDR_B0);
          state      <= S_EMPTY;
        end
      end
    end
  end

`ifdef CMDASM_ERRCNT_EN
  always_ff @(posedge clk_in) begin
    if (rst) begin
      err_cnt <= '0;
    end else if ((realign_hit || tmo_hit) && !(&err_cnt)) begin
      err_cnt <= err_cnt + 1'b1;
    end
  end
`endif

endmodule
